// File: rtl/pulse_capture_fifo.sv
// -----------------------------------------------------------------------------
// pulse_capture_fifo
//
// Purpose:
//   Watches the probe signal alongside the pulse-width measurement stage. On
//   every completed high pulse (falling edge of in_data) the width value the
//   measurement stage has just published is captured into a small FIFO. Also
//   keeps running statistics over all captured pulses (count, min, max),
//   including pulses whose FIFO write had to be dropped.
//
// Configuration macro:
//   PULSE_CAPTURE_STATS_EN
//     defined   : pulse_count / min_width / max_width are live registers.
//     undefined : stats registers are removed; outputs are tied to their
//                 reset values (0 / 0xFF / 0x00). FIFO and overflow unchanged.
//
// Parameters:
//   DEPTH  FIFO entries, power of two in 2..16
//   AW     pointer index width, must equal log2(DEPTH)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_data      in   probe signal
//   width_in     in   [7:0] width published by the measurement stage
//   clear        in   synchronous clear of FIFO, stats and overflow
//   rd_en        in   read request
//   rd_data      out  [7:0] last popped width, held between reads
//   rd_valid     out  one-cycle pulse when rd_data was updated
//   fifo_empty   out  no entries stored
//   fifo_full    out  DEPTH entries stored
//   overflow     out  sticky: a capture was dropped
//   pulse_count  out  [15:0] captured pulses, saturating
//   min_width    out  [7:0] smallest captured width
//   max_width    out  [7:0] largest captured width
// -----------------------------------------------------------------------------
module pulse_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_data,
  input  logic [7:0]  width_in,
  input  logic        clear,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] pulse_count,
  output logic [7:0]  min_width,
  output logic [7:0]  max_width
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic          in_q, in_d;
  logic          cap_pend_q, cap_pend_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic          fall_edge;
  logic          capture;
  logic          rd_accept;
  logic          wr_accept;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;

  // Edge detect, handshake qualification and FIFO pointer next-state.
  // A capture lands one cycle after the falling edge is seen, which is when
  // the measurement stage has its new width on width_in. clear wins over
  // both a coincident capture and a coincident read. A write into a full
  // FIFO is only allowed when the same cycle pops the head, so the slot
  // being overwritten has already been read out.
  always_comb begin
    fall_edge  = in_q & ~in_data;
    capture    = cap_pend_q & ~clear;
    rd_accept  = rd_en & ~fifo_empty & ~clear;
    wr_accept  = capture & (~fifo_full | rd_accept);

    in_d       = in_data;
    cap_pend_d = fall_edge & ~clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_accept;
    overflow_d = overflow_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (rd_accept) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      end
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else if (capture) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control and read-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= 1'b0;
      cap_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      in_q       <= in_d;
      cap_pend_q <= cap_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array needs no reset: an entry is only ever read after it was
  // written, which the pointers guarantee.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= width_in;
    end
  end

`ifdef PULSE_CAPTURE_STATS_EN
  logic [15:0] count_q, count_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  max_q, max_d;

  // Statistics follow every capture, written or dropped, so the count
  // reflects pulses seen rather than entries stored.
  always_comb begin
    count_d = count_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clear) begin
      count_d = 16'h0000;
      min_d   = 8'hFF;
      max_d   = 8'h00;
    end else if (capture) begin
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'h0001;
      end
      if (width_in < min_q) begin
        min_d = width_in;
      end
      if (width_in > max_q) begin
        max_d = width_in;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
      min_q   <= 8'hFF;
      max_q   <= 8'h00;
    end else begin
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign pulse_count = count_q;
  assign min_width   = min_q;
  assign max_width   = max_q;
`else
  assign pulse_count = 16'h0000;
  assign min_width   = 8'hFF;
  assign max_width   = 8'h00;
`endif

endmodule
